// File: rtl/pe_pkg.sv
// Shared constants, FSM state encoding and element helpers for the PE result path.
package pe_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N_ELEM = 64;

  typedef enum logic {IDLE, SEND} state_e;

  // ReLU is a pure select: negative elements become zero, no width change.
  function automatic logic [DATA_W-1:0] relu_elem(input logic signed [DATA_W-1:0] x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/psum_stream_out.sv
// Drains the engine psum vector on a rising finish and streams it one element
// per beat over valid/ready, with optional ReLU and a sticky overrun flag.
module psum_stream_out #(
  parameter int unsigned N_ELEM = pe_pkg::N_ELEM,
  parameter int unsigned DATA_W = pe_pkg::DATA_W,
  parameter bit          RELU   = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_ELEM*DATA_W-1:0] psum,
  input  logic                     finish,
  output logic [DATA_W-1:0]        out_data,
  output logic [5:0]               out_idx,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);
  import pe_pkg::*;

  localparam logic [5:0] LAST_IDX = 6'(N_ELEM - 1);

  function automatic logic [DATA_W-1:0] shape(input logic [DATA_W-1:0] x);
    return RELU ? relu_elem(x) : x;
  endfunction

  state_e                     state_q;
  logic                       finish_q;
  logic [N_ELEM*DATA_W-1:0]   hold_q;
  logic [5:0]                 idx_q;
  logic [DATA_W-1:0]          data_q;
  logic                       valid_q;
  logic                       last_q;
  logic                       done_q;
  logic                       overrun_q;

  logic                       start;
  logic [5:0]                 idx_inc;
  logic [DATA_W-1:0]          nxt_elem;
  logic [DATA_W-1:0]          first_elem;

  always_comb begin
    start      = finish & ~finish_q;
    idx_inc    = idx_q + 6'd1;
    nxt_elem   = hold_q[DATA_W*32'(idx_inc) +: DATA_W];
    first_elem = psum[DATA_W-1:0];
  end

  // Output data is registered one element ahead: the start edge loads element 0
  // straight from psum, each accepted beat loads the following held element.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      finish_q  <= 1'b0;
      hold_q    <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      finish_q <= finish;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            hold_q  <= psum;
            idx_q   <= '0;
            data_q  <= shape(first_elem);
            valid_q <= 1'b1;
            last_q  <= (LAST_IDX == 6'd0);
            state_q <= SEND;
          end
        end
        SEND: begin
          if (start) begin
            overrun_q <= 1'b1;
          end
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              idx_q   <= '0;
              data_q  <= '0;
            end else begin
              idx_q  <= idx_inc;
              data_q <= shape(nxt_elem);
              last_q <= (idx_inc == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = (state_q == SEND);
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule
